// File: rtl/toy_valu_drain_pkg.sv
// Shared types for the vector ALU drain path: activation modes and drain FSM states.
package toy_vpack;

  localparam int SHAMT_W = 5;
  localparam int MODE_W  = 2;

  typedef enum logic [MODE_W-1:0] {
    BYPASS = 2'd0,
    RELU   = 2'd1,
    LEAKY  = 2'd2,
    CLAMP  = 2'd3
  } act_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } valu_drain_state_e;

endpackage

// File: rtl/toy_valu_act.sv
// Single-lane combinational activation: bypass, ReLU, leaky ReLU (arithmetic shift), clamped ReLU.
module toy_valu_act
  import toy_vpack::*;
#(
  parameter int ELEM_W = 32
) (
  input  logic signed [ELEM_W-1:0]  x,
  input  act_mode_e                 mode,
  input  logic        [SHAMT_W-1:0] shamt,
  input  logic signed [ELEM_W-1:0]  clamp,
  output logic signed [ELEM_W-1:0]  y
);

  logic signed [ELEM_W-1:0] relu_s;
  logic signed [ELEM_W-1:0] leaky_s;
  logic                     shamt_big_s;

  // Shifting a negative value by ELEM_W or more saturates to -1.
  always_comb begin
    shamt_big_s = ({{(32-SHAMT_W){1'b0}}, shamt} >= 32'(ELEM_W));
    relu_s      = x[ELEM_W-1] ? {ELEM_W{1'b0}} : x;
    if (!x[ELEM_W-1]) begin
      leaky_s = x;
    end else if (shamt_big_s) begin
      leaky_s = {ELEM_W{1'b1}};
    end else begin
      leaky_s = x >>> shamt;
    end
  end

  always_comb begin
    y = x;
    case (mode)
      BYPASS: y = x;
      RELU:   y = relu_s;
      LEAKY:  y = leaky_s;
      CLAMP: begin
        if (clamp[ELEM_W-1]) begin
          y = {ELEM_W{1'b0}};
        end else if (relu_s > clamp) begin
          y = clamp;
        end else begin
          y = relu_s;
        end
      end
      default: y = x;
    endcase
  end

endmodule

// File: rtl/toy_valu_drain.sv
// Drains result rows from the systolic array, activates them lane-wise and writes
// consecutive vector registers through a two-stage pipeline that honours write backpressure.
module toy_valu_drain
  import toy_vpack::*;
#(
  parameter int LANES   = 8,
  parameter int ELEM_W  = 32,
  parameter int ROWS    = 8,
  parameter int V_IDX_W = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            op_valid,
  output logic                            op_ready,
  input  logic [MODE_W-1:0]               op_mode,
  input  logic [SHAMT_W-1:0]              op_shamt,
  input  logic [ELEM_W-1:0]               op_clamp,
  input  logic [$clog2(ROWS+1)-1:0]       op_rows,
  input  logic [V_IDX_W-1:0]              op_rd,
  input  logic [LANES*ELEM_W-1:0]         sa_din,
  output logic                            sa_shift_en,
  output logic                            reg_wr_en,
  input  logic                            reg_wr_ready,
  output logic [V_IDX_W-1:0]              reg_index,
  output logic [LANES*ELEM_W-1:0]         reg_data,
  output logic                            done
);

  localparam int ROW_W = $clog2(ROWS+1);
  localparam int DW    = LANES*ELEM_W;

  valu_drain_state_e state_r;
  valu_drain_state_e state_nx_s;

  logic [ROW_W-1:0]   rows_left_r;
  logic [ROW_W-1:0]   rows_clip_s;
  act_mode_e          mode_r;
  logic [SHAMT_W-1:0] shamt_r;
  logic [ELEM_W-1:0]  clamp_r;
  logic [V_IDX_W-1:0] next_idx_r;

  logic               s1_valid_r;
  logic [DW-1:0]      s1_data_r;
  logic [V_IDX_W-1:0] s1_idx_r;
  logic               s2_valid_r;
  logic [DW-1:0]      s2_data_r;
  logic [V_IDX_W-1:0] s2_idx_r;
  logic [DW-1:0]      act_row_s;

  logic op_ready_s;
  logic accept_s;
  logic wr_done_s;
  logic s2_load_s;
  logic s1_adv_s;
  logic shift_s;

  // Handshake and pipeline flow control; rst suppresses every shift and write in its cycle.
  always_comb begin
    op_ready_s  = (state_r == IDLE) && !rst;
    accept_s    = op_valid && op_ready_s;
    rows_clip_s = (op_rows > ROW_W'(ROWS)) ? ROW_W'(ROWS) : op_rows;
    wr_done_s   = s2_valid_r && reg_wr_ready && !rst;
    s2_load_s   = !s2_valid_r || wr_done_s;
    s1_adv_s    = s1_valid_r && s2_load_s;
    shift_s     = !rst && (state_r == DRAIN) && (rows_left_r != {ROW_W{1'b0}})
                  && (!s1_valid_r || s1_adv_s);
  end

  // FLUSH ends on the edge that leaves both stages empty, so done follows without a bubble.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nx_s = (rows_clip_s == {ROW_W{1'b0}}) ? DONE : DRAIN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      DRAIN: begin
        if (shift_s && (rows_left_r == ROW_W'(1'b1))) begin
          state_nx_s = FLUSH;
        end else begin
          state_nx_s = DRAIN;
        end
      end
      FLUSH: begin
        if (!s1_valid_r && (!s2_valid_r || wr_done_s)) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = FLUSH;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State register plus the command fields latched on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      rows_left_r <= {ROW_W{1'b0}};
      mode_r      <= BYPASS;
      shamt_r     <= {SHAMT_W{1'b0}};
      clamp_r     <= {ELEM_W{1'b0}};
      next_idx_r  <= {V_IDX_W{1'b0}};
    end else begin
      state_r <= state_nx_s;
      if (accept_s) begin
        rows_left_r <= rows_clip_s;
        mode_r      <= act_mode_e'(op_mode);
        shamt_r     <= op_shamt;
        clamp_r     <= op_clamp;
        next_idx_r  <= op_rd;
      end else if (shift_s) begin
        rows_left_r <= rows_left_r - ROW_W'(1'b1);
        next_idx_r  <= next_idx_r + {{(V_IDX_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Stage 1 captures the head row with its destination; stage 2 holds the activated row for the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= {DW{1'b0}};
      s1_idx_r   <= {V_IDX_W{1'b0}};
      s2_valid_r <= 1'b0;
      s2_data_r  <= {DW{1'b0}};
      s2_idx_r   <= {V_IDX_W{1'b0}};
    end else begin
      if (shift_s) begin
        s1_valid_r <= 1'b1;
        s1_data_r  <= sa_din;
        s1_idx_r   <= next_idx_r;
      end else if (s1_adv_s) begin
        s1_valid_r <= 1'b0;
      end
      if (s2_load_s) begin
        s2_valid_r <= s1_valid_r;
        if (s1_valid_r) begin
          s2_data_r <= act_row_s;
          s2_idx_r  <= s1_idx_r;
        end
      end
    end
  end

  for (genvar lane_g = 0; lane_g < LANES; lane_g++) begin : g_lane
    toy_valu_act #(
      .ELEM_W (ELEM_W)
    ) u_act (
      .x     (s1_data_r[lane_g*ELEM_W +: ELEM_W]),
      .mode  (mode_r),
      .shamt (shamt_r),
      .clamp (clamp_r),
      .y     (act_row_s[lane_g*ELEM_W +: ELEM_W])
    );
  end

  assign op_ready    = op_ready_s;
  assign sa_shift_en = shift_s;
  assign reg_wr_en   = s2_valid_r && !rst;
  assign reg_index   = s2_idx_r;
  assign reg_data    = s2_data_r;
  assign done        = (state_r == DONE) && !rst;

endmodule

// File: doc/toy_valu_drain.md
# toy_valu_drain

Parametrised post-processing vector ALU between the systolic array output and the vector register file. On one accepted command it pulls up to ROWS result rows from the array through the `sa_shift_en`/`sa_din` port. It applies a per-lane activation (bypass, ReLU, leaky ReLU, clamped ReLU) to each row and writes consecutive vector registers. Register-file backpressure is honoured without losing or duplicating rows.

## Interface

Parameters:

- `LANES`, 8: elements per row.
- `ELEM_W`, 32: signed element width.
- `ROWS`, 8: maximum rows per command.
- `V_IDX_W`, 5: vector register index width.

Ports:

- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `op_valid` in 1: command valid.
- `op_ready` out 1: command ready; high exactly when state is IDLE.
- `op_mode` in 2: activation mode; 0 BYPASS, 1 RELU, 2 LEAKY, 3 CLAMP.
- `op_shamt` in 5: LEAKY right-shift amount.
- `op_clamp` in ELEM_W: CLAMP upper bound, signed.
- `op_rows` in $clog2(ROWS+1): rows to drain.
- `op_rd` in V_IDX_W: base destination register.
- `sa_din` in LANES*ELEM_W: current head row of the array; lane i at bits [i*ELEM_W +: ELEM_W].
- `sa_shift_en` out 1: consume head row at this edge.
- `reg_wr_en` out 1: write request.
- `reg_wr_ready` in 1: register file accepts the write this cycle.
- `reg_index` out V_IDX_W: destination register.
- `reg_data` out LANES*ELEM_W: activated row.
- `done` out 1: one-cycle completion pulse.

## Operation

- **Command accept.** A command is accepted on `op_valid && op_ready`. All `op_*` fields are latched; later changes are ignored. `op_rows > ROWS` is treated as ROWS.
- **FSM states:** IDLE, DRAIN, FLUSH, DONE.
  - IDLE → DRAIN on accept with rows > 0.
  - IDLE → DONE on accept with rows = 0.
  - DRAIN → FLUSH when the last row has been shifted.
  - FLUSH → DONE when stage 1 and stage 2 are empty.
  - DONE → IDLE unconditionally. `done` = 1 only in DONE.
- **Pipeline.** Stage 1 holds the raw row and its row number. Stage 2 is the output register driving `reg_*`.
  - `reg_wr_en` = stage-2 valid.
  - A write completes on `reg_wr_en && reg_wr_ready`.
  - Stage 2 loads when it is empty or its write completes.
  - Stage 1 advances when stage 2 loads.
  - `sa_shift_en` = DRAIN && rows_left > 0 && (stage 1 empty || stage 1 advancing). `sa_din` is captured into stage 1 on that edge.
- **Indexing.** Row k is written to `reg_index = (op_rd + k) mod 2^V_IDX_W`. Writes complete in row order.
- **Activation** (per lane, x signed ELEM_W, result ELEM_W):
  - BYPASS: x.
  - RELU: x < 0 ? 0 : x.
  - LEAKY: x < 0 ? x >>> shamt : x. Arithmetic shift; shamt ≥ ELEM_W gives −1 for negative x.
  - CLAMP: y = RELU(x), then min(y, op_clamp). A negative `op_clamp` gives 0.
- **Reset.** `rst` high, including mid-command: the next edge forces IDLE and empties both stages, and the partial command is abandoned.
  - Reset values: `sa_shift_en` 0, `reg_wr_en` 0, `reg_index` 0, `reg_data` 0, `done` 0.
  - `op_ready` is 1 from the first cycle after reset deasserts.
  - No shift or write is issued in any cycle where `rst` is high.

## Timing

Commands are accepted in cycle 0 with N rows and no backpressure:

- `sa_shift_en` high in cycles 1..N.
- Row k is captured in stage 1 at the end of cycle k+1, giving `reg_wr_en` high in cycles 3..N+2 (row k in cycle k+3).
- FLUSH runs in cycles N+1..N+2, `done` pulses in cycle N+3, and `op_ready` returns high in cycle N+4.
- rows = 0: `done` in cycle 1, `op_ready` in cycle 2, no shift and no write.

Under backpressure:

- While `reg_wr_en && !reg_wr_ready`, `reg_index` and `reg_data` are held stable.
- `sa_shift_en` stays low while stage 1 is full and cannot advance.
- Total shifts equal total writes equal N.

Shifts and writes may coincide in the same cycle.

## Structure

- `toy_vpack` gains:
  - `act_mode_e` enum: BYPASS, RELU, LEAKY, CLAMP.
  - FSM state enum `valu_drain_state_e`.
- Sub-module `toy_valu_act`: combinational single-lane activation with ports x, mode, shamt, clamp → y. It is generated LANES times between stage 1 and stage 2.

## Test plan

1. **Reset.** Hold `rst` 2 cycles mid-idle → all outputs 0 during reset; `op_ready` = 1 the cycle after release.
2. **RELU, no backpressure.** rows = 3, rd = 5; lanes carry −3, 7, 0, −2147483648 → writes to indices 5, 6, 7 in cycles 3, 4, 5 with values 0, 7, 0, 0; `done` in cycle 6; exactly 3 shifts.
3. **LEAKY and CLAMP.**
   - LEAKY, shamt = 2: −8 → −2, −1 → −1, 12 → 12.
   - CLAMP, clamp = 6: −4 → 0, 3 → 3, 100 → 6.
   - CLAMP, clamp = −5: 9 → 0.
4. **Backpressure.** rows = 4, `reg_wr_ready` low in cycles 3–5 → `reg_data`/`reg_index` stable while stalled; `sa_shift_en` drops while stage 1 is full; 4 shifts and 4 writes in order, no duplicates.
5. **Wrap-around and zero/over-range rows.**
   - rd = 30, rows = 4 → indices 30, 31, 0, 1.
   - rows = 0 → `done` in cycle 1 with no shift and no write.
   - rows = 12 with ROWS = 8 → exactly 8 rows.
6. **Mid-command reset and back-to-back commands.**
   - Assert `rst` in cycle 2 of a rows = 4 command → no shift or write afterwards; IDLE with `op_ready` = 1 after release.
   - A second command then completes normally.
